// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU and load results into an in-order FIFO
// and drains one register-file write per cycle, flagging RAW hazards to decode.
module regfile_wb_ctrl #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [XLEN-1:0]          rf_wd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = CW + 1;

  logic [4:0]      mem_rd_q [DEPTH];
  logic [XLEN-1:0] mem_wd_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, ld_wptr_s;
  logic [CW-1:0]   count_q, count_d;
  logic            prio_q, prio_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic [FW-1:0]   free_s;
  logic            pop_s, alu_push_s, ld_push_s;
  logic            alu_ready_s, ld_ready_s;
  logic            hazard1_s, hazard2_s;
  logic [DEPTH-1:0] ent_vld_s;

  // Slot i is occupied when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    assign ent_vld_s[g] = ({1'b0, PW'(g) - rptr_q} < count_q);
  end

  function automatic logic pending_write(input logic [4:0] rs);
    logic hit;
    hit = rf_we_q && (rf_rd_q == rs);
    for (int i = 0; i < DEPTH; i++) begin
      hit = hit | (ent_vld_s[i] && (mem_rd_q[i] == rs));
    end
    return (rs != 5'd0) && hit;
  endfunction

  assign pop_s  = (count_q != CW'(0));
  assign free_s = FW'(DEPTH) - {1'b0, count_q} + FW'(pop_s);

  // Grant logic: a ready never looks at its own valid, only at the competitor's.
  always_comb begin
    alu_ready_s = 1'b0;
    ld_ready_s  = 1'b0;
    if (free_s >= FW'(2)) begin
      alu_ready_s = 1'b1;
      ld_ready_s  = 1'b1;
    end else if (free_s == FW'(1)) begin
      if (!prio_q) begin
        alu_ready_s = 1'b1;
        ld_ready_s  = !alu_valid;
      end else begin
        ld_ready_s  = 1'b1;
        alu_ready_s = !ld_valid;
      end
    end else begin
      alu_ready_s = 1'b0;
      ld_ready_s  = 1'b0;
    end
  end

  // Next-state: pushes (x0 targets are dropped), pop into the write port, priority swap.
  always_comb begin
    alu_push_s = alu_valid && alu_ready_s && (alu_rd != 5'd0);
    ld_push_s  = ld_valid && ld_ready_s && (ld_rd != 5'd0);
    ld_wptr_s  = alu_push_s ? (wptr_q + PW'(1)) : wptr_q;
    wptr_d     = wptr_q + PW'(alu_push_s) + PW'(ld_push_s);
    rptr_d     = rptr_q + PW'(pop_s);
    count_d    = count_q + CW'(alu_push_s) + CW'(ld_push_s) - CW'(pop_s);
    prio_d     = prio_q ^ ((free_s == FW'(1)) && alu_valid && ld_valid);
    rf_we_d    = pop_s;
    if (pop_s) begin
      rf_rd_d = mem_rd_q[rptr_q];
      rf_wd_d = mem_wd_q[rptr_q];
    end else begin
      rf_rd_d = rf_rd_q;
      rf_wd_d = rf_wd_q;
    end
  end

  // Control state and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= PW'(0);
      rptr_q  <= PW'(0);
      count_q <= CW'(0);
      prio_q  <= 1'b0;
      rf_we_q <= 1'b0;
      rf_rd_q <= 5'd0;
      rf_wd_q <= {XLEN{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      prio_q  <= prio_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  // FIFO storage; ALU entry lands first so a same-cycle load to the same rd wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd_q[i] <= 5'd0;
        mem_wd_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (alu_push_s) begin
        mem_rd_q[wptr_q] <= alu_rd;
        mem_wd_q[wptr_q] <= alu_data;
      end
      if (ld_push_s) begin
        mem_rd_q[ld_wptr_s] <= ld_rd;
        mem_wd_q[ld_wptr_s] <= ld_data;
      end
    end
  end

  // Hazard lookup against every buffered entry and the write in flight.
  always_comb begin
    hazard1_s = pending_write(rs1);
    hazard2_s = pending_write(rs2);
  end

  assign alu_ready = alu_ready_s;
  assign ld_ready  = ld_ready_s;
  assign hazard1   = hazard1_s;
  assign hazard2   = hazard2_s;
  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wd     = rf_wd_q;
  assign count     = count_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with hand-computed expectations.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]  alu_rd, ld_rd, rs1, rs2, rf_rd;
  logic [63:0] alu_data, ld_data, rf_wd;
  logic        hazard1, hazard2, rf_we;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl #(.XLEN(64), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] lwd);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = lwd;
    #1;
  endtask

  // Expected write stream of the contention/wrap phase, in accept order.
  logic [4:0]  exp_rd [10] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10, 5'd9};
  logic [63:0] exp_wd [10] = '{64'h10, 64'h20, 64'h11, 64'h21, 64'h12, 64'h22,
                               64'h13, 64'h23, 64'h24, 64'h14};
  int wi;

  task automatic check_write();
    check_eq("stream_we", {63'd0, rf_we}, 64'd1);
    check_eq("stream_rd", {59'd0, rf_rd}, {59'd0, exp_rd[wi]});
    check_eq("stream_wd", rf_wd, exp_wd[wi]);
    wi++;
  endtask

  initial begin
    reset = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("rst_count", {61'd0, count}, 64'd0);
    check_eq("rst_we", {63'd0, rf_we}, 64'd0);
    check_eq("rst_rd", {59'd0, rf_rd}, 64'd0);
    check_eq("rst_wd", rf_wd, 64'd0);
    check_eq("rst_ardy", {63'd0, alu_ready}, 64'd1);
    check_eq("rst_lrdy", {63'd0, ld_ready}, 64'd1);

    // Single ALU write and its latency / hazard window
    rs1 = 5'd5;
    drive(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0);
    check_eq("t1_haz_pre", {63'd0, hazard1}, 64'd0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    check_eq("t1_count1", {61'd0, count}, 64'd1);
    check_eq("t1_we0", {63'd0, rf_we}, 64'd0);
    check_eq("t1_haz_q", {63'd0, hazard1}, 64'd1);
    tick();
    check_eq("t1_we1", {63'd0, rf_we}, 64'd1);
    check_eq("t1_rd", {59'd0, rf_rd}, 64'd5);
    check_eq("t1_wd", rf_wd, 64'hDEAD_BEEF);
    check_eq("t1_count0", {61'd0, count}, 64'd0);
    check_eq("t1_haz_wr", {63'd0, hazard1}, 64'd1);
    tick();
    check_eq("t1_we_off", {63'd0, rf_we}, 64'd0);
    check_eq("t1_rd_hold", {59'd0, rf_rd}, 64'd5);
    check_eq("t1_haz_off", {63'd0, hazard1}, 64'd0);

    // Simultaneous ALU and load to the same rd: ALU first, load lands last
    drive(1'b1, 5'd3, 64'd1, 1'b1, 5'd3, 64'd2);
    check_eq("t2_ardy", {63'd0, alu_ready}, 64'd1);
    check_eq("t2_lrdy", {63'd0, ld_ready}, 64'd1);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    check_eq("t2_count", {61'd0, count}, 64'd2);
    tick();
    check_eq("t2_wd_a", rf_wd, 64'd1);
    check_eq("t2_count1", {61'd0, count}, 64'd1);
    tick();
    check_eq("t2_wd_b", rf_wd, 64'd2);
    check_eq("t2_rd_b", {59'd0, rf_rd}, 64'd3);
    tick();
    check_eq("t2_idle", {63'd0, rf_we}, 64'd0);

    // x0 destination: handshake completes, nothing enqueued
    rs1 = 5'd0;
    drive(1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'd0);
    check_eq("x0_ardy", {63'd0, alu_ready}, 64'd1);
    check_eq("x0_haz", {63'd0, hazard1}, 64'd0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    check_eq("x0_count", {61'd0, count}, 64'd0);
    tick();
    check_eq("x0_we", {63'd0, rf_we}, 64'd0);

    // Contention, priority toggle and pointer wrap
    wi = 0;
    rs2 = 5'd10;
    drive(1'b1, 5'd1, 64'h10, 1'b1, 5'd2, 64'h20);
    check_eq("c0_ardy", {63'd0, alu_ready}, 64'd1);
    check_eq("c0_lrdy", {63'd0, ld_ready}, 64'd1);
    tick();
    check_eq("c0_count", {61'd0, count}, 64'd2);
    drive(1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h21);
    check_eq("c1_lrdy", {63'd0, ld_ready}, 64'd1);
    tick();
    check_write();
    check_eq("c1_count", {61'd0, count}, 64'd3);
    drive(1'b1, 5'd5, 64'h12, 1'b1, 5'd6, 64'h22);
    check_eq("c2_ardy", {63'd0, alu_ready}, 64'd1);
    check_eq("c2_lrdy", {63'd0, ld_ready}, 64'd1);
    tick();
    check_write();
    check_eq("c2_count", {61'd0, count}, 64'd4);
    drive(1'b1, 5'd7, 64'h13, 1'b1, 5'd8, 64'h23);
    check_eq("c3_ardy", {63'd0, alu_ready}, 64'd1);
    check_eq("c3_lrdy", {63'd0, ld_ready}, 64'd0);
    tick();
    check_write();
    check_eq("c3_count", {61'd0, count}, 64'd4);
    drive(1'b1, 5'd9, 64'h14, 1'b1, 5'd8, 64'h23);
    check_eq("c4_ardy", {63'd0, alu_ready}, 64'd0);
    check_eq("c4_lrdy", {63'd0, ld_ready}, 64'd1);
    tick();
    check_write();
    drive(1'b0, 5'd9, 64'h14, 1'b1, 5'd10, 64'h24);
    check_eq("c5_ardy", {63'd0, alu_ready}, 64'd1);
    check_eq("c5_lrdy", {63'd0, ld_ready}, 64'd1);
    check_eq("c5_haz_pre", {63'd0, hazard2}, 64'd0);
    tick();
    check_write();
    check_eq("c5_haz", {63'd0, hazard2}, 64'd1);
    drive(1'b1, 5'd9, 64'h14, 1'b0, 5'd0, 64'd0);
    check_eq("c6_ardy", {63'd0, alu_ready}, 64'd1);
    check_eq("c6_lrdy", {63'd0, ld_ready}, 64'd0);
    tick();
    check_write();
    check_eq("c6_count", {61'd0, count}, 64'd4);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_write();
    end
    check_eq("drain_count", {61'd0, count}, 64'd0);
    tick();
    check_eq("drain_idle", {63'd0, rf_we}, 64'd0);

    // Asynchronous reset with entries buffered and a write in flight
    drive(1'b1, 5'd11, 64'h31, 1'b1, 5'd12, 64'h32);
    tick();
    drive(1'b1, 5'd13, 64'h33, 1'b1, 5'd14, 64'h34);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    rs1 = 5'd12; rs2 = 5'd13;
    #1;
    check_eq("r_count_pre", {61'd0, count}, 64'd3);
    check_eq("r_we_pre", {63'd0, rf_we}, 64'd1);
    check_eq("r_haz_pre", {63'd0, hazard1}, 64'd1);
    reset = 1'b1;
    #1;
    check_eq("r_we", {63'd0, rf_we}, 64'd0);
    check_eq("r_count", {61'd0, count}, 64'd0);
    check_eq("r_haz1", {63'd0, hazard1}, 64'd0);
    check_eq("r_haz2", {63'd0, hazard2}, 64'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("r_post_we", {63'd0, rf_we}, 64'd0);
    end
    check_eq("r_post_count", {61'd0, count}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
